data_memory_ls: RTL and testbench

- Parametrised, byte-addressable single-port data memory for the single-cycle/multi-cycle datapath. It replaces word-indexed storage.
- Supports byte, half and word load/store with sign or zero extension.
- Detects misaligned and out-of-range accesses.
- Read data passes through a configurable-latency response pipeline.
- Optional post-reset clear sweep.
- Sits between the ALU address path and the writeback mux.

---
 rtl/dmem_pkg.sv | 27 ++
 rtl/dmem_lane_align.sv | 82 ++++++++
 rtl/data_memory_ls.sv | 164 ++++++++++++++++
 tb/tb_data_memory_ls.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared encodings for data_memory_ls.
// Holds the access-size codes, the INIT/RUN state enum and a helper that
// maps a size code to the number of bytes it touches (0 for the illegal code).
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  function automatic logic [2:0] access_bytes(input logic [1:0] size);
    logic [2:0] n;
    case (size)
      SZ_BYTE: n = 3'd1;
      SZ_HALF: n = 3'd2;
      SZ_WORD: n = 3'd4;
      default: n = 3'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: combinational byte-lane steering for data_memory_ls.
// Ports: size_i/signed_i/addr_i/wdata_i describe the request, rword_i is the
//   32-bit word holding the addressed bytes; err_o flags illegal size,
//   misalignment or out-of-range, rdata_o is the extended load value (0 on
//   error), be_o/wword_o are the per-byte write enables (0 on error) and the
//   lane-replicated store data.
module dmem_lane_align
  import dmem_pkg::*;
#(
  parameter int MEM_BYTES = 32,
  parameter int ADDR_W    = 32
) (
  input  logic [1:0]        size_i,
  input  logic              signed_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  input  logic [31:0]       rword_i,
  output logic              err_o,
  output logic [31:0]       rdata_o,
  output logic [3:0]        be_o,
  output logic [31:0]       wword_o
);

  logic [1:0]      ofs;
  logic [ADDR_W:0] end_addr;
  logic            misalign;
  logic            range_err;
  logic [7:0]      b;
  logic [15:0]     h;

  assign ofs = addr_i[1:0];

  // One extra bit keeps addresses near the top of the address space from
  // wrapping back into the array.
  assign end_addr  = {1'b0, addr_i} + {{(ADDR_W-2){1'b0}}, access_bytes(size_i)};
  assign range_err = end_addr > (ADDR_W+1)'(MEM_BYTES);

  always_comb begin
    misalign = 1'b0;
    case (size_i)
      SZ_HALF: misalign = ofs[0];
      SZ_WORD: misalign = |ofs;
      default: misalign = 1'b0;
    endcase
  end

  assign err_o = (size_i == SZ_ILL) | misalign | range_err;

  // Aligned accesses never straddle a word, so lanes come from one word.
  assign b = rword_i[{ofs, 3'b000} +: 8];
  assign h = ofs[1] ? rword_i[31:16] : rword_i[15:0];

  always_comb begin
    rdata_o = 32'h0;
    if (!err_o) begin
      case (size_i)
        SZ_BYTE: rdata_o = {{24{b[7] & signed_i}}, b};
        SZ_HALF: rdata_o = {{16{h[15] & signed_i}}, h};
        default: rdata_o = rword_i;
      endcase
    end
  end

  always_comb begin
    be_o    = 4'b0000;
    wword_o = wdata_i;
    case (size_i)
      SZ_BYTE: begin
        be_o    = 4'b0001 << ofs;
        wword_o = {4{wdata_i[7:0]}};
      end
      SZ_HALF: begin
        be_o    = ofs[1] ? 4'b1100 : 4'b0011;
        wword_o = {2{wdata_i[15:0]}};
      end
      SZ_WORD: be_o = 4'b1111;
      default: be_o = 4'b0000;
    endcase
    if (err_o) be_o = 4'b0000;
  end

endmodule

// File: rtl/data_memory_ls.sv
// data_memory_ls: byte-addressable single-port data memory with byte/half/word
//   load/store, sign/zero extension, error detection and a READ_LATENCY-deep
//   response pipeline (one response per accepted request, in order, no backpressure).
// Ports: clk/rst (async active-high); req_* request channel with req_ready;
//   rsp_valid/rsp_rdata/rsp_err response channel.
// Build option: define DMEM_INIT_CLEAR_EN to zero the array after every reset
//   (MEM_BYTES/4 cycles with req_ready low); otherwise ready after one edge.
module data_memory_ls
  import dmem_pkg::*;
#(
  parameter int MEM_BYTES    = 32,
  parameter int ADDR_W       = 32,
  parameter int READ_LATENCY = 1    // legal 1..4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int WORDS = MEM_BYTES / 4;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  logic [31:0] mem_q [WORDS];

  state_e state_q, state_d;

  logic             accept;
  logic             wr_en;
  logic [IDX_W-1:0] word_idx;
  logic [31:0]      rword;
  logic [31:0]      ld_data;
  logic [31:0]      st_word;
  logic [3:0]       st_be;
  logic             acc_err;

  logic [READ_LATENCY-1:0] vld_q;
  logic [READ_LATENCY-1:0] err_q;
  logic [31:0]             dat_q [READ_LATENCY];

  assign word_idx = req_addr[IDX_W+1:2];
  // Out-of-range indices only arise on errored requests; read 0 for them.
  assign rword    = (int'(word_idx) < WORDS) ? mem_q[word_idx] : 32'h0;

  dmem_lane_align #(
    .MEM_BYTES (MEM_BYTES),
    .ADDR_W    (ADDR_W)
  ) u_align (
    .size_i   (req_size),
    .signed_i (req_signed),
    .addr_i   (req_addr),
    .wdata_i  (req_wdata),
    .rword_i  (rword),
    .err_o    (acc_err),
    .rdata_o  (ld_data),
    .be_o     (st_be),
    .wword_o  (st_word)
  );

  assign accept = req_valid & req_ready;
  assign wr_en  = accept & req_write;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_INIT;
    else     state_q <= state_d;
  end

`ifdef DMEM_INIT_CLEAR_EN
  logic             clr_en;
  logic             clr_last;
  logic [IDX_W-1:0] clr_cnt_q, clr_cnt_d;

  assign clr_last = (int'(clr_cnt_q) == WORDS - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) clr_cnt_q <= '0;
    else     clr_cnt_q <= clr_cnt_d;
  end

  always_comb begin
    clr_cnt_d = clr_cnt_q;
    if (clr_en) clr_cnt_d = clr_last ? '0 : clr_cnt_q + 1'b1;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT: if (clr_last) state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase
  end

  always_comb begin
    req_ready = (state_q == ST_RUN);
    clr_en    = (state_q == ST_INIT);
  end

  // Sweep writes take priority; requests cannot arrive during INIT anyway.
  always_ff @(posedge clk) begin
    if (clr_en) begin
      mem_q[clr_cnt_q] <= 32'h0;
    end else if (wr_en) begin
      for (int l = 0; l < 4; l++) begin
        if (st_be[l]) mem_q[word_idx][8*l +: 8] <= st_word[8*l +: 8];
      end
    end
  end
`else
  // Without the sweep, INIT only holds req_ready low for the first edge
  // after reset release.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT: state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase
  end

  always_comb begin
    req_ready = (state_q == ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int l = 0; l < 4; l++) begin
        if (st_be[l]) mem_q[word_idx][8*l +: 8] <= st_word[8*l +: 8];
      end
    end
  end
`endif

  // ---------------------------------------------------- response pipeline
  // Stores and errored loads carry zero data so rsp_rdata is 0 for them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      err_q <= '0;
      for (int i = 0; i < READ_LATENCY; i++) dat_q[i] <= 32'h0;
    end else begin
      vld_q[0] <= accept;
      err_q[0] <= accept & acc_err;
      dat_q[0] <= (accept && !req_write) ? ld_data : 32'h0;
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        err_q[i] <= err_q[i-1];
        dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign rsp_valid = vld_q[READ_LATENCY-1];
  assign rsp_err   = err_q[READ_LATENCY-1];
  assign rsp_rdata = dat_q[READ_LATENCY-1];

endmodule

// File: tb/tb_data_memory_ls.sv
module tb_data_memory_ls;
  import dmem_pkg::*;

  localparam int MEM_BYTES = 32;
  localparam int ADDR_W    = 32;
  localparam int LAT       = 3;
  localparam int WORDS     = MEM_BYTES / 4;

`ifdef DMEM_INIT_CLEAR_EN
  localparam int          INIT_CYC = MEM_BYTES / 4;
  localparam logic [31:0] EXP08    = 32'h0000_0000;
  localparam logic [31:0] EXP10    = 32'h0000_0000;
`else
  localparam int          INIT_CYC = 1;
  localparam logic [31:0] EXP08    = 32'hDEAD_5AEF;
  localparam logic [31:0] EXP10    = 32'hCAFE_F00D;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int n_checks = 0;
  int n_errors = 0;

  // Back-to-back stream: store, load of the same word next cycle, then loads.
  logic        s_wr   [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  logic [31:0] s_addr [5] = '{32'h10, 32'h10, 32'h00, 32'h04, 32'h08};
  logic [31:0] s_wd   [5] = '{32'hCAFE_F00D, 32'h0, 32'h0, 32'h0, 32'h0};
  logic [31:0] s_exp  [5] = '{32'h0, 32'hCAFE_F00D, 32'h0, 32'h0, 32'hDEAD_5AEF};

  always #5 clk = ~clk;

  data_memory_ls #(
    .MEM_BYTES    (MEM_BYTES),
    .ADDR_W       (ADDR_W),
    .READ_LATENCY (LAT)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic wr, input logic [1:0] sz,
                       input logic sg, input logic [31:0] a, input logic [31:0] wd);
    req_valid  = v;
    req_write  = wr;
    req_size   = sz;
    req_signed = sg;
    req_addr   = a;
    req_wdata  = wd;
  endtask

  // Issue one request, then wait (bounded) for its response and check it.
  task automatic do_req(input string tag, input logic wr, input logic [1:0] sz,
                        input logic sg, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_d, input logic exp_e);
    int lat;
    drive(1'b1, wr, sz, sg, a, wd);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, SZ_BYTE, 1'b0, 32'h0, 32'h0);
    lat = 1;
    while (!rsp_valid && lat < 12) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(LAT));
    check({tag, " rdata"}, rsp_rdata, exp_d);
    check({tag, " err"}, 32'(rsp_err), 32'(exp_e));
  endtask

  task automatic wait_ready(input string tag, input int exp_cycles);
    int   n;
    logic saw;
    n   = 0;
    saw = 1'b0;
    while (!req_ready && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (rsp_valid) saw = 1'b1;
    end
    check({tag, " ready cycles"}, 32'(n), 32'(exp_cycles));
    check({tag, " no rsp during init"}, 32'(saw), 32'h0);
  endtask

  initial begin
    logic saw;

    // ---- reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst req_ready", 32'(req_ready), 32'h0);
    check("rst rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst rsp_rdata", rsp_rdata, 32'h0);
    check("rst rsp_err", 32'(rsp_err), 32'h0);
    rst = 1'b0;
    #1;
    check("release req_ready", 32'(req_ready), 32'h0);
    wait_ready("init", INIT_CYC);

`ifdef DMEM_INIT_CLEAR_EN
    do_req("clr lw00", 1'b0, SZ_WORD, 1'b0, 32'h00, 32'h0, 32'h0, 1'b0);
    do_req("clr lw1c", 1'b0, SZ_WORD, 1'b0, 32'h1C, 32'h0, 32'h0, 1'b0);
`endif
    // Define every word so later expectations are independent of power-up.
    for (int w = 0; w < WORDS; w++)
      do_req("fill", 1'b1, SZ_WORD, 1'b0, 32'(4 * w), 32'h0, 32'h0, 1'b0);

    // ---- main function
    do_req("lw00",   1'b0, SZ_WORD, 1'b0, 32'h00, 32'h0,         32'h0000_0000, 1'b0);
    do_req("sw08",   1'b1, SZ_WORD, 1'b0, 32'h08, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0);
    do_req("lb0b",   1'b0, SZ_BYTE, 1'b1, 32'h0B, 32'h0,         32'hFFFF_FFDE, 1'b0);
    do_req("lbu08",  1'b0, SZ_BYTE, 1'b0, 32'h08, 32'h0,         32'h0000_00EF, 1'b0);
    do_req("lh0a",   1'b0, SZ_HALF, 1'b1, 32'h0A, 32'h0,         32'hFFFF_DEAD, 1'b0);
    do_req("lhu0a",  1'b0, SZ_HALF, 1'b0, 32'h0A, 32'h0,         32'h0000_DEAD, 1'b0);
    do_req("lw08s",  1'b0, SZ_WORD, 1'b1, 32'h08, 32'h0,         32'hDEAD_BEEF, 1'b0);
    do_req("sb09",   1'b1, SZ_BYTE, 1'b0, 32'h09, 32'h1234_565A, 32'h0000_0000, 1'b0);
    do_req("lw08",   1'b0, SZ_WORD, 1'b0, 32'h08, 32'h0,         32'hDEAD_5AEF, 1'b0);
    do_req("sh0e",   1'b1, SZ_HALF, 1'b0, 32'h0E, 32'hFFFF_8001, 32'h0000_0000, 1'b0);
    do_req("lh0e",   1'b0, SZ_HALF, 1'b1, 32'h0E, 32'h0,         32'hFFFF_8001, 1'b0);
    do_req("lb0f",   1'b0, SZ_BYTE, 1'b1, 32'h0F, 32'h0,         32'hFFFF_FF80, 1'b0);
    do_req("lw0c",   1'b0, SZ_WORD, 1'b0, 32'h0C, 32'h0,         32'h8001_0000, 1'b0);

    // ---- errors and boundaries
    do_req("lw06 misalign", 1'b0, SZ_WORD, 1'b0, 32'h06, 32'h0,  32'h0, 1'b1);
    do_req("sh03 misalign", 1'b1, SZ_HALF, 1'b0, 32'h03, 32'hFFFF, 32'h0, 1'b1);
    do_req("lw00 intact",   1'b0, SZ_WORD, 1'b0, 32'h00, 32'h0,  32'h0, 1'b0);
    do_req("lw1c",          1'b0, SZ_WORD, 1'b0, 32'h1C, 32'h0,  32'h0, 1'b0);
    do_req("lw1d",          1'b0, SZ_WORD, 1'b0, 32'h1D, 32'h0,  32'h0, 1'b1);
    do_req("lw20",          1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0,  32'h0, 1'b1);
    do_req("size11",        1'b0, SZ_ILL,  1'b0, 32'h00, 32'h0,  32'h0, 1'b1);
    do_req("lb1f",          1'b0, SZ_BYTE, 1'b0, 32'h1F, 32'h0,  32'h0, 1'b0);
    do_req("lh1f",          1'b0, SZ_HALF, 1'b0, 32'h1F, 32'h0,  32'h0, 1'b1);
    do_req("sb20 oob",      1'b1, SZ_BYTE, 1'b0, 32'h20, 32'hAA, 32'h0, 1'b1);
    do_req("sw wrap",       1'b1, SZ_WORD, 1'b0, 32'hFFFF_FFFC, 32'h1111_1111, 32'h0, 1'b1);
    do_req("lw wrap",       1'b0, SZ_WORD, 1'b0, 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b1);
    do_req("lw00 no alias", 1'b0, SZ_WORD, 1'b0, 32'h00, 32'h0,  32'h0, 1'b0);
    do_req("lw1c no alias", 1'b0, SZ_WORD, 1'b0, 32'h1C, 32'h0,  32'h0, 1'b0);

    // ---- back-to-back stream: responses on consecutive cycles, in order
    for (int j = 0; j < 9; j++) begin
      if (j < 5) drive(1'b1, s_wr[j], SZ_WORD, 1'b0, s_addr[j], s_wd[j]);
      else       drive(1'b0, 1'b0, SZ_BYTE, 1'b0, 32'h0, 32'h0);
      @(posedge clk); #1;
      check($sformatf("stream vld c%0d", j), 32'(rsp_valid), 32'((j >= 2) && (j <= 6)));
      if (j >= 2 && j <= 6) begin
        check($sformatf("stream rdata r%0d", j - 2), rsp_rdata, s_exp[j-2]);
        check($sformatf("stream err r%0d", j - 2), 32'(rsp_err), 32'h0);
      end
    end

    // ---- reset with responses in flight
    drive(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h08, 32'h0);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h00, 32'h0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, SZ_BYTE, 1'b0, 32'h0, 32'h0);
    check("pre-rst vld", 32'(rsp_valid), 32'h1);
    check("pre-rst rdata", rsp_rdata, 32'hDEAD_5AEF);
    rst = 1'b1;
    #1;
    check("rst drop vld", 32'(rsp_valid), 32'h0);
    check("rst drop rdata", rsp_rdata, 32'h0);
    check("rst drop ready", 32'(req_ready), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    wait_ready("reinit", INIT_CYC);
    saw = 1'b0;
    for (int k = 0; k < LAT + 2; k++) begin
      @(posedge clk); #1;
      if (rsp_valid) saw = 1'b1;
    end
    check("no rsp after reset", 32'(saw), 32'h0);
    do_req("post-rst lw08", 1'b0, SZ_WORD, 1'b0, 32'h08, 32'h0, EXP08, 1'b0);
    do_req("post-rst lw10", 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, EXP10, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
